// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/decode/execute sequencer with a
// return-address stack and a timed coprocessor start/done handshake.
module cpu_seq_ctrl #(
    parameter int STACK_DEPTH = 4,
    parameter int COP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] imem_addr,
    input  logic [18:0] imem_rdata,
    output logic [18:0] ir,
    input  logic [3:0]  opcode,
    input  logic [10:0] jump_addr,
    input  logic [10:0] call_addr,
    input  logic [7:0]  branch_addr,
    input  logic        branch_taken,
    output logic        reg_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        cop_start,
    output logic [1:0]  cop_sel,
    input  logic        cop_done,
    output logic [10:0] pc,
    output logic        stack_err,
    output logic        cop_timeout
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int CW  = $clog2(COP_TIMEOUT + 1);

    localparam logic [2:0] S_FETCH    = 3'd0;
    localparam logic [2:0] S_DECODE   = 3'd1;
    localparam logic [2:0] S_EXEC     = 3'd2;
    localparam logic [2:0] S_MEM      = 3'd3;
    localparam logic [2:0] S_WB       = 3'd4;
    localparam logic [2:0] S_COP_WAIT = 3'd5;

    localparam logic [3:0] OP_JUMP   = 4'b0011;
    localparam logic [3:0] OP_BRANCH = 4'b0100;
    localparam logic [3:0] OP_LOAD   = 4'b0101;
    localparam logic [3:0] OP_STORE  = 4'b0110;
    localparam logic [3:0] OP_CALL   = 4'b0111;
    localparam logic [3:0] OP_RET    = 4'b1000;
    localparam logic [3:0] OP_ENC    = 4'b1001;
    localparam logic [3:0] OP_DEC    = 4'b1010;
    localparam logic [3:0] OP_FFT    = 4'b1011;

    logic [2:0]     state_q, state_d;
    logic [10:0]    pc_q, pc_d;
    logic [18:0]    ir_q, ir_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [10:0]    stack_q [STACK_DEPTH];
    logic [10:0]    stack_d [STACK_DEPTH];
    logic           reg_we_q, reg_we_d;
    logic           mem_re_q, mem_re_d;
    logic           mem_we_q, mem_we_d;
    logic           cop_start_q, cop_start_d;
    logic [1:0]     cop_sel_q, cop_sel_d;
    logic           stack_err_q, stack_err_d;
    logic           cop_timeout_q, cop_timeout_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;

    logic [10:0]    pc_inc;
    logic [10:0]    stack_top;

    assign pc_inc = pc_q + 11'd1;

    always_comb begin
        stack_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (SPW'(i + 1) == sp_q) begin
                stack_top = stack_q[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        sp_d          = sp_q;
        stack_d       = stack_q;
        reg_we_d      = 1'b0;
        mem_re_d      = 1'b0;
        mem_we_d      = 1'b0;
        cop_start_d   = 1'b0;
        cop_sel_d     = cop_sel_q;
        stack_err_d   = stack_err_q;
        cop_timeout_d = cop_timeout_q;
        wait_cnt_d    = wait_cnt_q;

        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end

            S_DECODE: begin
                ir_d    = imem_rdata;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
                case (opcode)
                    OP_JUMP: begin
                        pc_d = jump_addr;
                    end
                    OP_BRANCH: begin
                        if (branch_taken) begin
                            pc_d = {3'b000, branch_addr};
                        end
                    end
                    OP_LOAD: begin
                        mem_re_d = 1'b1;
                        state_d  = S_MEM;
                    end
                    OP_STORE: begin
                        mem_we_d = 1'b1;
                        state_d  = S_MEM;
                    end
                    OP_CALL: begin
                        if (sp_q < SPW'(STACK_DEPTH)) begin
                            for (int i = 0; i < STACK_DEPTH; i++) begin
                                if (SPW'(i) == sp_q) begin
                                    stack_d[i] = pc_inc;
                                end
                            end
                            sp_d = sp_q + SPW'(1);
                            pc_d = call_addr;
                        end else begin
                            stack_err_d = 1'b1;
                        end
                    end
                    OP_RET: begin
                        if (sp_q != '0) begin
                            sp_d = sp_q - SPW'(1);
                            pc_d = stack_top;
                        end else begin
                            stack_err_d = 1'b1;
                        end
                    end
                    OP_ENC, OP_DEC, OP_FFT: begin
                        cop_start_d = 1'b1;
                        cop_sel_d   = opcode[1:0];
                        wait_cnt_d  = '0;
                        state_d     = S_COP_WAIT;
                    end
                    default: begin
                        reg_we_d = 1'b1;
                        state_d  = S_WB;
                    end
                endcase
            end

            S_MEM: begin
                if (mem_re_q) begin
                    reg_we_d = 1'b1;
                    state_d  = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_WB: begin
                state_d = S_FETCH;
            end

            S_COP_WAIT: begin
                // done is not trusted while the start pulse is still out
                if (cop_done && !cop_start_q) begin
                    cop_sel_d = 2'b00;
                    state_d   = S_FETCH;
                end else if (wait_cnt_q == CW'(COP_TIMEOUT - 1)) begin
                    cop_timeout_d = 1'b1;
                    cop_sel_d     = 2'b00;
                    state_d       = S_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= '0;
            ir_q          <= '0;
            sp_q          <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            reg_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            cop_start_q   <= 1'b0;
            cop_sel_q     <= 2'b00;
            stack_err_q   <= 1'b0;
            cop_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            sp_q          <= sp_d;
            stack_q       <= stack_d;
            reg_we_q      <= reg_we_d;
            mem_re_q      <= mem_re_d;
            mem_we_q      <= mem_we_d;
            cop_start_q   <= cop_start_d;
            cop_sel_q     <= cop_sel_d;
            stack_err_q   <= stack_err_d;
            cop_timeout_q <= cop_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign ir          = ir_q;
    assign reg_we      = reg_we_q;
    assign mem_re      = mem_re_q;
    assign mem_we      = mem_we_q;
    assign cop_start   = cop_start_q;
    assign cop_sel     = cop_sel_q;
    assign stack_err   = stack_err_q;
    assign cop_timeout = cop_timeout_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: synchronous ROM, field decoder and an
// instruction-level reference model driving per-cycle expectations.
module tb_cpu_seq_ctrl;

    localparam int DEPTH = 4;
    localparam int TO    = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] imem_addr;
    logic [18:0] imem_rdata;
    logic [18:0] ir;
    logic [3:0]  opcode;
    logic [10:0] jump_addr;
    logic [10:0] call_addr;
    logic [7:0]  branch_addr;
    logic        branch_taken = 1'b0;
    logic        reg_we, mem_re, mem_we, cop_start;
    logic [1:0]  cop_sel;
    logic        cop_done = 1'b0;
    logic [10:0] pc;
    logic        stack_err, cop_timeout;

    logic [18:0] rom [0:2047];
    int total = 0;
    int bad   = 0;

    logic [10:0] mpc;
    logic [10:0] mstack [$];
    bit          merr, mto;

    typedef struct {
        logic [18:0] instr;
        bit          taken;
        logic [10:0] pc4;
        logic [11:0] we_m;
        logic [11:0] re_m;
        logic [11:0] wr_m;
        bit          err;
    } vec_t;
    vec_t vecs [10];

    always #5 clk = ~clk;
    always @(posedge clk) imem_rdata <= rom[imem_addr];

    assign opcode      = ir[18:15];
    assign jump_addr   = ir[10:0];
    assign call_addr   = ir[10:0];
    assign branch_addr = ir[7:0];

    cpu_seq_ctrl #(.STACK_DEPTH(DEPTH), .COP_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .ir(ir),
        .opcode(opcode), .jump_addr(jump_addr), .call_addr(call_addr),
        .branch_addr(branch_addr), .branch_taken(branch_taken),
        .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
        .cop_start(cop_start), .cop_sel(cop_sel), .cop_done(cop_done),
        .pc(pc), .stack_err(stack_err), .cop_timeout(cop_timeout)
    );

    function automatic void chk(string nm, int unsigned act, int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endfunction

    function automatic logic [5:0] strb();
        return {reg_we, mem_re, mem_we, cop_start, cop_sel};
    endfunction

    function automatic logic [18:0] mk(logic [3:0] op, logic [10:0] a);
        return {op, 4'b0000, a};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 2048; i++) rom[i] = '0;
    endtask

    task automatic model_reset();
        mpc  = '0;
        mstack.delete();
        merr = 1'b0;
        mto  = 1'b0;
    endtask

    // leaves the bench at the negedge of the first FETCH cycle
    task automatic do_reset();
        rst = 1'b1;
        cop_done = 1'b0;
        branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // runs the instruction at mpc from its FETCH to the next FETCH
    task automatic run_one(input bit taken, input int dly, input bit early);
        logic [18:0] ins;
        logic [3:0]  op;
        logic [10:0] nxt;
        logic [1:0]  sel;
        bit          fin;
        ins = rom[mpc];
        op  = ins[18:15];
        nxt = mpc + 11'd1;
        chk("fetch_addr", imem_addr, mpc);
        chk("pc", pc, mpc);
        chk("stack_err", stack_err, merr);
        chk("cop_timeout", cop_timeout, mto);
        chk("fetch_strobes", strb(), 0);
        branch_taken = taken;
        @(negedge clk);
        chk("decode_strobes", strb(), 0);
        @(negedge clk);
        chk("exec_strobes", strb(), 0);
        cop_done = early;
        case (op)
            4'd3: nxt = ins[10:0];
            4'd4: if (taken) nxt = {3'b000, ins[7:0]};
            4'd7: begin
                if (mstack.size() < DEPTH) begin
                    mstack.push_back(nxt);
                    nxt = ins[10:0];
                end else merr = 1'b1;
            end
            4'd8: begin
                if (mstack.size() > 0) nxt = mstack.pop_back();
                else merr = 1'b1;
            end
            default: ;
        endcase
        case (op)
            4'd3, 4'd4, 4'd7, 4'd8: ;
            4'd5: begin
                @(negedge clk); cop_done = 1'b0;
                chk("load_mem", strb(), 6'b010000);
                @(negedge clk);
                chk("load_wb", strb(), 6'b100000);
            end
            4'd6: begin
                @(negedge clk); cop_done = 1'b0;
                chk("store_mem", strb(), 6'b001000);
            end
            4'd9, 4'd10, 4'd11: begin
                sel = (op == 4'd9) ? 2'd1 : (op == 4'd10) ? 2'd2 : 2'd3;
                fin = 1'b0;
                for (int k = 0; k < TO && !fin; k++) begin
                    @(negedge clk);
                    cop_done = (k == 0) ? early : (k == dly);
                    if (k == 0) chk("cop_start_cyc", strb(), {4'b0001, sel});
                    else chk("cop_wait_cyc", strb(), {4'b0000, sel});
                    if (k > 0 && k == dly) fin = 1'b1;
                    else if (k == TO - 1) mto = 1'b1;
                end
            end
            default: begin
                @(negedge clk); cop_done = 1'b0;
                chk("rtype_wb", strb(), 6'b100000);
            end
        endcase
        @(negedge clk);
        cop_done = 1'b0;
        mpc = nxt;
    endtask

    initial begin
        logic [11:0] wm, rm, xm;
        logic [10:0] a4;
        logic [7:0]  m8;
        logic [10:0] exp_ret [4];

        vecs[0] = '{mk(4'd1, 11'h0),   0, 11'h001, 12'h888, 12'h000, 12'h000, 0};
        vecs[1] = '{mk(4'd3, 11'h100), 0, 11'h100, 12'h440, 12'h000, 12'h000, 0};
        vecs[2] = '{mk(4'd4, 11'h020), 1, 11'h020, 12'h440, 12'h000, 12'h000, 0};
        vecs[3] = '{mk(4'd4, 11'h020), 0, 11'h001, 12'h440, 12'h000, 12'h000, 0};
        vecs[4] = '{mk(4'd5, 11'h0),   0, 11'h001, 12'h110, 12'h008, 12'h000, 0};
        vecs[5] = '{mk(4'd6, 11'h0),   0, 11'h001, 12'h880, 12'h000, 12'h008, 0};
        vecs[6] = '{mk(4'd15, 11'h7),  0, 11'h001, 12'h888, 12'h000, 12'h000, 0};
        vecs[7] = '{mk(4'd0, 11'h0),   0, 11'h001, 12'h888, 12'h000, 12'h000, 0};
        vecs[8] = '{mk(4'd8, 11'h0),   0, 11'h001, 12'h440, 12'h000, 12'h000, 1};
        vecs[9] = '{mk(4'd7, 11'h050), 0, 11'h050, 12'h440, 12'h000, 12'h000, 0};
        exp_ret = '{11'h031, 11'h021, 11'h011, 11'h001};

        clear_rom();
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_ir", ir, 0);
        chk("rst_strobes", strb(), 0);
        chk("rst_flags", {stack_err, cop_timeout}, 0);

        for (int v = 0; v < 10; v++) begin
            clear_rom();
            rom[0] = vecs[v].instr;
            do_reset();
            branch_taken = vecs[v].taken;
            wm = '0; rm = '0; xm = '0; a4 = '0;
            for (int c = 1; c <= 12; c++) begin
                if (c > 1) @(negedge clk);
                wm[c-1] = reg_we;
                rm[c-1] = mem_re;
                xm[c-1] = mem_we;
                if (c == 4) a4 = imem_addr;
            end
            chk($sformatf("vec%0d_reg_we", v), wm, vecs[v].we_m);
            chk($sformatf("vec%0d_mem_re", v), rm, vecs[v].re_m);
            chk($sformatf("vec%0d_mem_we", v), xm, vecs[v].wr_m);
            chk($sformatf("vec%0d_pc", v), a4, vecs[v].pc4);
            chk($sformatf("vec%0d_err", v), stack_err, vecs[v].err);
        end

        clear_rom();
        rom[1] = mk(4'd3, 11'h100);
        do_reset();
        m8 = '0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            m8[c-1] = reg_we;
            if (c == 8) chk("rj_pc", imem_addr, 11'h100);
        end
        chk("rj_reg_we", m8, 8'h08);

        clear_rom();
        rom[0] = mk(4'd3, 11'd5);
        rom[5] = mk(4'd4, 11'h020);
        do_reset();
        run_one(0, 1, 0);
        run_one(1, 1, 0);
        chk("br_taken_pc", pc, 11'h020);
        do_reset();
        run_one(0, 1, 0);
        run_one(0, 1, 0);
        chk("br_not_pc", pc, 11'h006);

        clear_rom();
        rom[0]     = mk(4'd7, 11'h010);
        rom[11'h010] = mk(4'd7, 11'h020);
        rom[11'h020] = mk(4'd7, 11'h030);
        rom[11'h030] = mk(4'd7, 11'h040);
        rom[11'h040] = mk(4'd7, 11'h050);
        rom[11'h041] = mk(4'd8, 11'h0);
        rom[11'h031] = mk(4'd8, 11'h0);
        rom[11'h021] = mk(4'd8, 11'h0);
        rom[11'h011] = mk(4'd8, 11'h0);
        rom[11'h001] = mk(4'd8, 11'h0);
        do_reset();
        for (int i = 0; i < 4; i++) run_one(0, 1, 0);
        chk("call4_err", stack_err, 0);
        run_one(0, 1, 0);
        chk("call5_err", stack_err, 1);
        chk("call5_pc", pc, 11'h041);
        for (int i = 0; i < 4; i++) begin
            run_one(0, 1, 0);
            chk($sformatf("ret%0d_pc", i), pc, exp_ret[i]);
        end
        run_one(0, 1, 0);
        chk("ret5_pc", pc, 11'h002);
        chk("ret5_err", stack_err, 1);

        clear_rom();
        rom[0] = mk(4'd11, 11'h0);
        do_reset();
        run_one(0, 10, 1);
        chk("fft_pc", pc, 11'h001);
        chk("fft_no_timeout", cop_timeout, 0);

        clear_rom();
        rom[0] = mk(4'd9, 11'h0);
        do_reset();
        run_one(0, 1000, 0);
        chk("to_flag", cop_timeout, 1);
        chk("to_pc", pc, 11'h001);
        run_one(0, 1, 0);

        clear_rom();
        rom[0] = mk(4'd3, 11'h7FF);
        rom[11'h7FF] = mk(4'd1, 11'h0);
        do_reset();
        run_one(0, 1, 0);
        run_one(0, 1, 0);
        chk("wrap_addr", imem_addr, 0);

        clear_rom();
        rom[0] = mk(4'd10, 11'h0);
        do_reset();
        repeat (5) @(negedge clk);
        chk("cw_sel", cop_sel, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("cw_rst_pc", pc, 0);
        chk("cw_rst_strobes", strb(), 0);
        rst = 1'b0;
        model_reset();
        run_one(0, 3, 0);

        clear_rom();
        for (int i = 0; i < 2048; i++) begin
            rom[i] = {4'($urandom_range(0, 15)), 15'($urandom)};
        end
        do_reset();
        for (int n = 0; n < 400; n++) begin
            run_one(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 29) == 0) ? 1000 : $urandom_range(1, 12),
                    1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_seq_ctrl.md
CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port imem_addr, output, 11 bits: instruction memory address, equal to pc.
REQ-004 SHALL have port imem_rdata, input, 19 bits: instruction word, valid one cycle after imem_addr is presented (synchronous ROM).
REQ-005 SHALL have port ir, output, 19 bits: latched instruction register, feeding the instruction decoder.
REQ-006 SHALL have port opcode, input, 4 bits: decoded opcode, i.e. ir[18:15] from the decoder.
REQ-007 SHALL have ports jump_addr and call_addr, input, 11 bits each, and branch_addr, input, 8 bits: decoded targets.
REQ-008 SHALL have port branch_taken, input, 1 bit: comparator result for rs1/rs2, valid in EXEC.
REQ-009 SHALL have ports reg_we, mem_re and mem_we, output, 1 bit each: register-file write, data-memory read and data-memory write strobes.
REQ-010 SHALL have port cop_start, output, 1 bit: one-cycle coprocessor start pulse.
REQ-011 SHALL have port cop_sel, output, 2 bits: coprocessor select (01 encrypt, 10 decrypt, 11 fft, 00 none).
REQ-012 SHALL have port cop_done, input, 1 bit: coprocessor completion.
REQ-013 SHALL have ports pc, output, 11 bits; stack_err, output, 1 bit, sticky; cop_timeout, output, 1 bit, sticky.
REQ-014 SHALL have parameter STACK_DEPTH, default 4: return-address stack entries.
REQ-015 SHALL have parameter COP_TIMEOUT, default 255: maximum wait in cycles for cop_done.

Function
REQ-016 SHALL use the states FETCH, DECODE, EXEC, MEM, WB and COP_WAIT, one-hot or binary.
REQ-017 FETCH SHALL drive imem_addr=pc and then go to DECODE.
REQ-018 DECODE SHALL latch ir<=imem_rdata and then go to EXEC.
REQ-019 EXEC SHALL compute and load next pc for every opcode; the default is pc+1 mod 2048 (2047 wraps to 0).
REQ-020 Opcode 0001/0010 (R/I): EXEC -> WB; WB SHALL assert reg_we for 1 cycle, then go to FETCH; total 4 cycles.
REQ-021 Opcode 0011 (jump): pc<=jump_addr; EXEC -> FETCH; 3 cycles.
REQ-022 Opcode 0100 (branch): pc<={3'b000,branch_addr} if branch_taken, else pc+1; EXEC -> FETCH.
REQ-023 Opcode 0101 (load): EXEC -> MEM (mem_re=1) -> WB (reg_we=1) -> FETCH; 5 cycles.
REQ-024 Opcode 0110 (store): EXEC -> MEM (mem_we=1) -> FETCH; 4 cycles.
REQ-025 Opcode 0111 (call): if sp<STACK_DEPTH, SHALL push pc+1, sp++ and set pc<=call_addr; if full, SHALL set stack_err=1, push nothing and set pc<=pc+1.
REQ-026 Opcode 1000 (ret): if sp>0, SHALL set sp-- and pc<=top entry; if empty, SHALL set stack_err=1 and pc<=pc+1.
REQ-027 Opcodes 1001/1010/1011: EXEC SHALL pulse cop_start for exactly 1 cycle with cop_sel=01/10/11 respectively, then go to COP_WAIT.
REQ-028 cop_sel SHALL hold its value through COP_WAIT and return to 00 on exit.
REQ-029 cop_done SHALL be sampled only in COP_WAIT; cop_done asserted during the EXEC/cop_start cycle SHALL be ignored.
REQ-030 COP_WAIT SHALL exit to FETCH on the cycle cop_done=1 is sampled.
REQ-031 COP_WAIT wait counter: SHALL clear on entry and increment every cycle; if it reaches COP_TIMEOUT without cop_done, SHALL set cop_timeout=1 and go to FETCH (the instruction is abandoned).
REQ-032 Opcodes 0000 and 1100-1111 SHALL be executed as R-type (as REQ-020).
REQ-033 reg_we, mem_re, mem_we and cop_start SHALL be registered, mutually exclusive, and never asserted in FETCH or DECODE.
REQ-034 stack_err and cop_timeout SHALL clear only on rst.

Reset
REQ-035 While rst=1 at a clock edge, SHALL force state=FETCH, pc=0, ir=0, sp=0, all stack entries=0, all strobes=0, cop_sel=00, stack_err=0, cop_timeout=0 and wait counter=0.
REQ-036 rst asserted mid-instruction (including COP_WAIT) SHALL abort that instruction; no strobe SHALL be asserted in the cycle after the reset edge.
REQ-037 After rst deasserts, the first FETCH SHALL present imem_addr=0.

Verification
REQ-038 ROM[0]=R-type, ROM[1]=jump to 0x100 -> reg_we high in cycle 4 only; pc=0x100 after cycle 7.
REQ-039 Branch at pc=5 with branch_addr=0x20: branch_taken=1 -> pc=0x020; branch_taken=0 -> pc=6.
REQ-040 Five nested calls with STACK_DEPTH=4 -> 5th call sets stack_err=1 and pc=call pc+1; four rets return in LIFO order; a 5th ret keeps stack_err=1 and gives pc+1.
REQ-041 FFT opcode, cop_done raised 10 cycles after cop_start -> cop_start is a 1-cycle pulse, cop_sel=11 throughout the wait, FETCH follows the cop_done cycle; cop_done pulsed during the start cycle has no effect.
REQ-042 cop_done never asserted -> cop_timeout=1 after 255 COP_WAIT cycles, then pc=pc+1 and fetch resumes.
REQ-043 pc=2047 with an R-type instruction -> next fetch at imem_addr=0; rst asserted in COP_WAIT -> pc=0, all strobes 0 next cycle.
